// File: rtl/control_sumador_pkg.sv
// control_sumador_pkg: shared FSM states and widths for the two-client adder sequencer.
package control_sumador_pkg;
    localparam int ANCHO_DEF = 8;
    localparam int RES_W = ANCHO_DEF + 1;
    typedef enum logic [1:0] {LIBRE = 2'd0, SUMA = 2'd1, ENTREGA = 2'd2} estado_t;
endpackage

// File: rtl/control_sumador_arbitro_rr2.sv
// arbitro_rr2: combinational two-way winner select; prio breaks ties only.
module arbitro_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic g,
    output logic valid
);
    assign valid = req0 | req1;
    assign g     = (req0 & req1) ? prio : req1;
endmodule

// File: rtl/sumador8b.sv
// sumador8b: 8-bit unsigned adder with 9-bit result (bit 8 = carry).
module sumador8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/control_sumador.sv
// control_sumador: round-robin sequencer sharing one sumador8b between two clients.
// Optional saturating per-client op counters enabled by CONTADOR_OPS_EN.
module control_sumador
    import control_sumador_pkg::*;
#(
    parameter int ANCHO        = ANCHO_DEF,
    parameter bit PRIO_INICIAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [ANCHO-1:0] a0,
    input  logic [ANCHO-1:0] b0,
    input  logic             req1,
    input  logic [ANCHO-1:0] a1,
    input  logic [ANCHO-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [RES_W-1:0] res,
    output logic             res_id,
    output logic             cout,
    output logic             busy,
    output logic [7:0]       n_ops0,
    output logic [7:0]       n_ops1
);
    if (ANCHO != 8) begin : g_ancho_invalido
        $error("control_sumador: ANCHO must be 8 to match sumador8b");
    end

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [RES_W-1:0] res_q, res_d, suma;
    logic             id_q, id_d, prio_q, prio_d, res_id_q, res_id_d, cout_q, cout_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d, g, valid;

    arbitro_rr2 u_arb (.req0(req0), .req1(req1), .prio(prio_q), .g(g), .valid(valid));
    sumador8b u_sum (.a(op_a_q), .b(op_b_q), .s(suma));

    // ENTREGA and the unused encoding both fall through to LIBRE with acks low.
    always_comb begin
        estado_d = LIBRE;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        id_d     = id_q;
        prio_d   = prio_q;
        res_d    = res_q;
        res_id_d = res_id_q;
        cout_d   = cout_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        case (estado_q)
            LIBRE: if (valid) begin
                op_a_d   = g ? a1 : a0;
                op_b_d   = g ? b1 : b0;
                id_d     = g;
                prio_d   = ~g;
                estado_d = SUMA;
            end
            SUMA: begin
                res_d    = suma;
                cout_d   = suma[RES_W-1];
                res_id_d = id_q;
                ack0_d   = ~id_q;
                ack1_d   = id_q;
                estado_d = ENTREGA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= LIBRE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            id_q     <= 1'b0;
            prio_q   <= PRIO_INICIAL;
            res_q    <= '0;
            res_id_q <= 1'b0;
            cout_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            id_q     <= id_d;
            prio_q   <= prio_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
            cout_q   <= cout_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign res    = res_q;
    assign res_id = res_id_q;
    assign cout   = cout_q;
    assign busy   = estado_q != LIBRE;

`ifdef CONTADOR_OPS_EN
    logic [7:0] n0_q, n1_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n0_q <= '0;
            n1_q <= '0;
        end else begin
            if (ack0_d && n0_q != 8'hFF) n0_q <= n0_q + 8'd1;
            if (ack1_d && n1_q != 8'hFF) n1_q <= n1_q + 8'd1;
        end
    end
    assign n_ops0 = n0_q;
    assign n_ops1 = n1_q;
`else
    assign n_ops0 = 8'd0;
    assign n_ops1 = 8'd0;
`endif
endmodule

// File: tb/tb_control_sumador.sv
// tb_control_sumador: directed + randomized bench with a transaction-level reference model.
module tb_control_sumador;
    localparam bit PRIO = 1'b0;

    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic ack0, ack1, res_id, cout, busy;
    logic [8:0] res;
    logic [7:0] n_ops0, n_ops1;

    int tests = 0, fails = 0;

    control_sumador #(.ANCHO(8), .PRIO_INICIAL(PRIO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .res(res), .res_id(res_id),
        .cout(cout), .busy(busy), .n_ops0(n_ops0), .n_ops1(n_ops1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an accepted request completes one cycle later, then one idle-return cycle.
    int         m_t = -1;
    bit         m_prio = PRIO, m_gid, m_rid, m_ack0, m_ack1;
    logic [8:0] m_sum, m_res = '0;
    int         m_n0 = 0, m_n1 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = -1; m_prio = PRIO; m_res = '0; m_rid = 0; m_ack0 = 0; m_ack1 = 0; m_n0 = 0; m_n1 = 0;
        end else begin
            m_ack0 = 0;
            m_ack1 = 0;
            if (m_t == 0) begin
                m_res = m_sum;
                m_rid = m_gid;
                if (m_gid) begin m_ack1 = 1; if (m_n1 < 255) m_n1++; end
                else begin m_ack0 = 1; if (m_n0 < 255) m_n0++; end
                m_t = 1;
            end else if (m_t == 1) begin
                m_t = -1;
            end else if (req0 || req1) begin
                m_gid  = (req0 && req1) ? m_prio : req1;
                m_sum  = m_gid ? 9'(a1) + 9'(b1) : 9'(a0) + 9'(b0);
                m_prio = !m_gid;
                m_t    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ack0", ack0, m_ack0);
            chk("ack1", ack1, m_ack1);
            chk("ack_excl", ack0 & ack1, 0);
            chk("res", res, m_res);
            chk("res_id", res_id, m_rid);
            chk("cout", cout, m_res[8]);
            chk("busy", busy, m_t != -1);
`ifdef CONTADOR_OPS_EN
            chk("n_ops0", n_ops0, m_n0);
            chk("n_ops1", n_ops1, m_n1);
`else
            chk("n_ops0", n_ops0, 0);
            chk("n_ops1", n_ops1, 0);
`endif
        end
    end

    function automatic logic [7:0] rnd_op();
        return ($urandom_range(3) == 0) ? ($urandom_range(1) ? 8'hFF : 8'h00) : 8'($urandom);
    endfunction

    initial begin
        int who[$];
        int when[$];
        logic [8:0] sums[$];
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_res", res, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        rst = 1'b0;

        // Single request 15+12
        @(negedge clk); req0 = 1; a0 = 15; b0 = 12;
        @(negedge clk); chk("single_busy1", busy, 1); chk("single_noack", ack0, 0);
        @(negedge clk); chk("single_ack0", ack0, 1); chk("single_res", res, 27);
        chk("single_id", res_id, 0); chk("single_cout", cout, 0); chk("single_busy2", busy, 1);
        req0 = 0;
        @(negedge clk); chk("single_ackfall", ack0, 0); chk("single_idle", busy, 0);

        // Carry 255+255
        req1 = 1; a1 = 255; b1 = 255;
        @(negedge clk);
        @(negedge clk); chk("carry_ack1", ack1, 1); chk("carry_res", res, 510);
        chk("carry_cout", cout, 1); chk("carry_id", res_id, 1); chk("carry_ack0", ack0, 0);
        req1 = 0;
        @(negedge clk);

        // Tie, both held continuously
        req0 = 1; a0 = 5; b0 = 5; req1 = 1; a1 = 6; b1 = 13;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (ack0) begin who.push_back(0); when.push_back(i); sums.push_back(res); end
            if (ack1) begin who.push_back(1); when.push_back(i); sums.push_back(res); end
        end
        req0 = 0; req1 = 0;
        chk("tie_count", who.size() >= 4, 1);
        if (who.size() >= 4) begin
            chk("tie_order0", who[0], 0); chk("tie_order1", who[1], 1);
            chk("tie_order2", who[2], 0); chk("tie_order3", who[3], 1);
            chk("tie_res0", sums[0], 10); chk("tie_res1", sums[1], 19);
            chk("tie_res2", sums[2], 10); chk("tie_res3", sums[3], 19);
            chk("tie_gap", when[3] - when[2], 3);
        end
        repeat (4) @(negedge clk);

        // Late withdrawal of req0; req1 withdrawn before any grant
        req0 = 1; a0 = 100; b0 = 27;
        @(negedge clk); req0 = 0; req1 = 1; a1 = 1; b1 = 1;
        @(negedge clk); chk("late_ack0", ack0, 1); chk("late_res", res, 127); req1 = 0;
        repeat (4) begin @(negedge clk); chk("late_noack1", ack1, 0); end

        // Async reset while in SUMA
        req0 = 1; a0 = 7; b0 = 8;
        @(posedge clk); #2;
        rst = 1; req0 = 0;
        #1 chk("arst_busy", busy, 0); chk("arst_res", res, 0); chk("arst_acks", {ack0, ack1}, 0);
        #1 rst = 0;
        repeat (3) begin @(negedge clk); chk("arst_noack", ack0 | ack1, 0); end
        req0 = 1; a0 = 1; b0 = 2; req1 = 1; a1 = 3; b1 = 4;
        @(negedge clk); @(negedge clk);
        chk("arst_tie_ack0", ack0, 1); chk("arst_tie_res", res, 3); chk("arst_tie_id", res_id, 0);
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);

        // 300+ back-to-back client-0 ops from a fresh reset
        rst = 1; @(negedge clk); rst = 0;
        req0 = 1; a0 = 1; b0 = 1;
        repeat (905) @(negedge clk);
        req0 = 0;
        repeat (3) @(negedge clk);
`ifdef CONTADOR_OPS_EN
        chk("sat_n0", n_ops0, 255);
`else
        chk("sat_n0", n_ops0, 0);
`endif
        chk("sat_n1", n_ops1, 0);

        // Randomized protocol-abiding clients
        repeat (3000) begin
            @(negedge clk);
            if (req0 && ack0) req0 = 0;
            else if (!req0 && $urandom_range(2) == 0) begin req0 = 1; a0 = rnd_op(); b0 = rnd_op(); end
            else if (req0 && !busy && $urandom_range(15) == 0) req0 = 0;
            if (req1 && ack1) req1 = 0;
            else if (!req1 && $urandom_range(2) == 0) begin req1 = 1; a1 = rnd_op(); b1 = rnd_op(); end
            else if (req1 && !busy && $urandom_range(15) == 0) req1 = 0;
        end
        req0 = 0; req1 = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
